cpu_run_ctrl: RTL and testbench

CPU_RUN_CTRL -- requirements
Module: cpu_run_ctrl

---
 rtl/cpu_run_ctrl_pkg.sv | 19 +
 rtl/cpu_run_ctrl_sat_counter.sv | 27 ++
 rtl/cpu_run_ctrl.sv | 161 ++++++++++++++++
 tb/tb_cpu_run_ctrl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_run_ctrl_pkg.sv
// Shared constants for the CPU run controller: the run-state encoding and the
// default self-loop instruction word that marks program completion.
package cpu_run_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RST_HOLD = 2'd0,
    ST_RUN      = 2'd1,
    ST_HALT     = 2'd2,
    ST_TIMEOUT  = 2'd3
  } run_state_e;

  // beq $0,$0,-1 : branch-to-self, the conventional end-of-program marker
  localparam logic [31:0] HALT_WORD_DEFAULT = 32'h1000_FFFF;

  function automatic logic is_done_state(input run_state_e s);
    return (s == ST_HALT) || (s == ST_TIMEOUT);
  endfunction

endpackage

// File: rtl/cpu_run_ctrl_sat_counter.sv
// Up-counter with synchronous clear and enable that sticks at all-ones
// instead of wrapping.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         i_clr,
  input  logic         i_en,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  // Count register: clear has priority, then saturating increment
  always_ff @(posedge clk) begin
    if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != {W{1'b1}})) begin
      r_cnt <= r_cnt + W'(1'b1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run controller for a test CPU: holds the core in reset, lets it run, and
// stops it on a halt instruction, a stalled PC, or an exhausted cycle budget.
module cpu_run_ctrl
  import cpu_run_ctrl_pkg::*;
#(
  parameter int unsigned RESET_CYCLES = 5,
  parameter int unsigned MAX_CYCLES   = 100000,
  parameter int unsigned STALL_LIMIT  = 8,
  parameter int unsigned PC_W         = 32,
  parameter int unsigned CNT_W        = 32,
  parameter logic [31:0] HALT_WORD    = HALT_WORD_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             restart,
  input  logic             pc_valid,
  input  logic [PC_W-1:0]  pc,
  input  logic [31:0]      instr,
  output logic             cpu_reset,
  output logic             run,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] cycle_count,
  output logic [PC_W-1:0]  halt_pc
);

  localparam int unsigned        STALL_W    = $clog2(STALL_LIMIT + 1);
  localparam logic [7:0]         HOLD_LAST  = 8'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0]   CYCLE_LAST = CNT_W'(MAX_CYCLES - 1);
  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(STALL_LIMIT - 1);

  run_state_e       r_state;
  run_state_e       w_state_nxt;
  logic [7:0]       r_hold_cnt;
  logic [PC_W-1:0]  r_last_pc;
  logic [PC_W-1:0]  r_halt_pc;
  logic [CNT_W-1:0] w_cycle_cnt;
  logic [STALL_W-1:0] w_stall_cnt;

  logic w_in_run;
  logic w_repeat;
  logic w_new_pc;
  logic w_halt_word;
  logic w_stall_halt;
  logic w_halt_hit;
  logic w_restart_go;
  logic w_cycle_clr;
  logic w_cycle_en;
  logic w_stall_clr;
  logic w_stall_en;

  assign w_in_run     = (r_state == ST_RUN);
  assign w_repeat     = pc_valid && (pc == r_last_pc);
  assign w_new_pc     = pc_valid && (pc != r_last_pc);
  assign w_halt_word  = pc_valid && (instr == HALT_WORD);
  // The repeat seen this cycle is the one that brings stall_cnt to the limit
  assign w_stall_halt = w_repeat && (w_stall_cnt >= STALL_LAST);
  assign w_halt_hit   = w_in_run && (w_halt_word || w_stall_halt);
  assign w_restart_go = is_done_state(r_state) && restart;

  // Next-state decision; halt beats timeout when both fire together
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RST_HOLD: begin
        if (r_hold_cnt == HOLD_LAST) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = ST_RST_HOLD;
        end
      end
      ST_RUN: begin
        if (w_halt_hit) begin
          w_state_nxt = ST_HALT;
        end else if (w_cycle_cnt == CYCLE_LAST) begin
          w_state_nxt = ST_TIMEOUT;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_HALT, ST_TIMEOUT: begin
        if (restart) begin
          w_state_nxt = ST_RST_HOLD;
        end else begin
          w_state_nxt = r_state;
        end
      end
      default: w_state_nxt = ST_RST_HOLD;
    endcase
  end

  // State, reset-hold counter and PC capture registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_RST_HOLD;
      r_hold_cnt <= 8'd0;
      r_last_pc  <= '0;
      r_halt_pc  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == ST_RST_HOLD) && (w_state_nxt == ST_RST_HOLD)) begin
        r_hold_cnt <= r_hold_cnt + 8'd1;
      end else begin
        r_hold_cnt <= 8'd0;
      end
      if (w_restart_go) begin
        r_last_pc <= '0;
        r_halt_pc <= '0;
      end else begin
        if (w_in_run && w_new_pc) begin
          r_last_pc <= pc;
        end
        if (w_halt_hit) begin
          r_halt_pc <= w_halt_word ? pc : r_last_pc;
        end
      end
    end
  end

  // The budget counter stops one short of MAX_CYCLES on the timeout edge
  assign w_cycle_clr = reset || w_restart_go;
  assign w_cycle_en  = w_in_run && (w_state_nxt != ST_TIMEOUT);
  assign w_stall_clr = reset || w_restart_go || (w_in_run && w_new_pc);
  assign w_stall_en  = w_in_run && w_repeat;

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk   (clk),
    .i_clr (w_cycle_clr),
    .i_en  (w_cycle_en),
    .o_cnt (w_cycle_cnt)
  );

  sat_counter #(.W(STALL_W)) u_stall_cnt (
    .clk   (clk),
    .i_clr (w_stall_clr),
    .i_en  (w_stall_en),
    .o_cnt (w_stall_cnt)
  );

  // Status outputs decoded from the registered state only
  always_comb begin
    cpu_reset = 1'b0;
    run       = 1'b0;
    done      = 1'b0;
    timeout   = 1'b0;
    case (r_state)
      ST_RST_HOLD: cpu_reset = 1'b1;
      ST_RUN:      run       = 1'b1;
      ST_HALT:     done      = 1'b1;
      ST_TIMEOUT: begin
        done    = 1'b1;
        timeout = 1'b1;
      end
      default:     cpu_reset = 1'b1;
    endcase
  end

  assign cycle_count = w_cycle_cnt;
  assign halt_pc     = r_halt_pc;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Self-checking bench for cpu_run_ctrl: directed vector table, hand-written
// corner sequences, then random traffic against a behavioural model.
module tb_cpu_run_ctrl;

  localparam int RC = 5;
  localparam int MC = 20;
  localparam int SL = 8;
  localparam logic [31:0] HW = 32'h1000_FFFF;

  localparam int M_HOLD = 0;
  localparam int M_RUN  = 1;
  localparam int M_HALT = 2;
  localparam int M_TO   = 3;

  logic        clk = 1'b0;
  logic        reset, restart, pc_valid;
  logic [31:0] pc, instr;
  logic        cpu_reset, run, done, timeout;
  logic [31:0] cycle_count, halt_pc;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  cpu_run_ctrl #(
    .RESET_CYCLES(RC), .MAX_CYCLES(MC), .STALL_LIMIT(SL),
    .PC_W(32), .CNT_W(32), .HALT_WORD(HW)
  ) dut (
    .clk(clk), .reset(reset), .restart(restart), .pc_valid(pc_valid),
    .pc(pc), .instr(instr), .cpu_reset(cpu_reset), .run(run), .done(done),
    .timeout(timeout), .cycle_count(cycle_count), .halt_pc(halt_pc)
  );

  typedef struct {
    logic        rst, rs, pv;
    logic [31:0] pc, instr;
    logic        e_cr, e_run, e_done, e_to;
    logic [31:0] e_cc, e_hpc;
  } vec_t;

  vec_t vecs[13];

  // Behavioural model: mode plus plain integer bookkeeping
  int          m_mode = M_HOLD;
  int          m_hold_seen = 0;
  longint      m_cycles = 0;
  int          m_repeats = 0;
  logic [31:0] m_last = '0;
  logic [31:0] m_hpc = '0;

  task automatic m_step(input logic r, rs, pv, input logic [31:0] p, ins);
    bit is_hw, is_rep;
    is_hw  = pv && (ins == HW);
    is_rep = pv && (p == m_last);
    if (r) begin
      m_mode = M_HOLD; m_hold_seen = 0; m_cycles = 0; m_repeats = 0; m_last = '0; m_hpc = '0;
    end else if (m_mode == M_HOLD) begin
      m_hold_seen++;
      if (m_hold_seen == RC) begin
        m_mode = M_RUN;
        m_hold_seen = 0;
      end
    end else if (m_mode == M_RUN) begin
      if (is_hw || (is_rep && (m_repeats + 1 >= SL))) begin
        m_mode = M_HALT;
        m_hpc = p;
        m_cycles++;
      end else if (m_cycles + 1 == MC) begin
        m_mode = M_TO;
      end else begin
        m_cycles++;
      end
      if (is_rep) m_repeats++;
      else if (pv) begin
        m_repeats = 0;
        m_last = p;
      end
    end else if (rs) begin
      m_mode = M_HOLD; m_hold_seen = 0; m_cycles = 0; m_repeats = 0; m_last = '0; m_hpc = '0;
    end
  endtask

  task automatic tick(input logic r, rs, pv, input logic [31:0] p, ins);
    reset = r; restart = rs; pc_valid = pv; pc = p; instr = ins;
    m_step(r, rs, pv, p, ins);
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string name, input logic cr, rn, dn, to,
                           input logic [31:0] cc, hpc);
    n_cmp++;
    if ({cpu_reset, run, done, timeout, cycle_count, halt_pc} !== {cr, rn, dn, to, cc, hpc}) begin
      n_bad++;
      $display("FAIL %s: got cpu_reset=%b run=%b done=%b timeout=%b cycle_count=%0d halt_pc=%h, want cpu_reset=%b run=%b done=%b timeout=%b cycle_count=%0d halt_pc=%h",
               name, cpu_reset, run, done, timeout, cycle_count, halt_pc, cr, rn, dn, to, cc, hpc);
    end
  endtask

  function automatic vec_t mk(input logic r, rs, pv, input logic [31:0] p, ins,
                              input logic cr, rn, dn, to, input logic [31:0] cc, hpc);
    vec_t v;
    v.rst = r; v.rs = rs; v.pv = pv; v.pc = p; v.instr = ins;
    v.e_cr = cr; v.e_run = rn; v.e_done = dn; v.e_to = to; v.e_cc = cc; v.e_hpc = hpc;
    return v;
  endfunction

  task automatic run_incrementing(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b1, base + 32'(4 * i), 32'h0);
  endtask

  initial begin
    logic [31:0] cur_pc;
    logic        r, rs, pv;
    logic [31:0] ins;

    reset = 1'b1; restart = 1'b0; pc_valid = 1'b0; pc = 32'h0; instr = 32'h0;

    // Directed table: reset hold length, halt-word stop, freeze, restart
    vecs[0]  = mk(1'b1, 1'b0, 1'b0, 32'h0,    32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'h0);
    vecs[1]  = mk(1'b1, 1'b1, 1'b1, 32'h3000, HW,    1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'h0);
    vecs[2]  = mk(1'b0, 1'b0, 1'b0, 32'h0,    32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'h0);
    vecs[3]  = mk(1'b0, 1'b0, 1'b0, 32'h0,    32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'h0);
    vecs[4]  = mk(1'b0, 1'b0, 1'b0, 32'h0,    32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'h0);
    vecs[5]  = mk(1'b0, 1'b0, 1'b0, 32'h0,    32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'h0);
    vecs[6]  = mk(1'b0, 1'b0, 1'b0, 32'h0,    32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 32'h0);
    vecs[7]  = mk(1'b0, 1'b0, 1'b1, 32'h3000, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd1, 32'h0);
    vecs[8]  = mk(1'b0, 1'b0, 1'b1, 32'h3004, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd2, 32'h0);
    vecs[9]  = mk(1'b0, 1'b0, 1'b1, 32'h3008, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd3, 32'h0);
    vecs[10] = mk(1'b0, 1'b0, 1'b1, 32'h300C, HW,    1'b0, 1'b0, 1'b1, 1'b0, 32'd4, 32'h300C);
    vecs[11] = mk(1'b0, 1'b0, 1'b1, 32'h4000, HW,    1'b0, 1'b0, 1'b1, 1'b0, 32'd4, 32'h300C);
    vecs[12] = mk(1'b0, 1'b1, 1'b0, 32'h0,    32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'h0);

    for (int i = 0; i < 13; i++) begin
      tick(vecs[i].rst, vecs[i].rs, vecs[i].pv, vecs[i].pc, vecs[i].instr);
      check_out($sformatf("vec%0d", i), vecs[i].e_cr, vecs[i].e_run, vecs[i].e_done,
                vecs[i].e_to, vecs[i].e_cc, vecs[i].e_hpc);
    end

    // Stall halt: first 0x3010 loads last_pc, the 8th repeat stops the run
    repeat (RC) tick(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    check_out("stall_enter_run", 1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 32'h0);
    repeat (8) tick(1'b0, 1'b0, 1'b1, 32'h3010, 32'h0);
    check_out("stall_7_repeats", 1'b0, 1'b1, 1'b0, 1'b0, 32'd8, 32'h0);
    tick(1'b0, 1'b0, 1'b1, 32'h3010, 32'h0);
    check_out("stall_halt", 1'b0, 1'b0, 1'b1, 1'b0, 32'd9, 32'h3010);

    // Timeout with restart ignored while running
    tick(1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
    check_out("restart_from_halt", 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'h0);
    repeat (RC) tick(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick(1'b0, 1'b1, 1'b1, 32'h5000, 32'h0);
    check_out("restart_ignored_run", 1'b0, 1'b1, 1'b0, 1'b0, 32'd1, 32'h0);
    run_incrementing(MC - 2, 32'h5004);
    check_out("timeout_pre", 1'b0, 1'b1, 1'b0, 1'b0, 32'(MC - 1), 32'h0);
    tick(1'b0, 1'b0, 1'b1, 32'h6000, 32'h0);
    check_out("timeout", 1'b0, 1'b0, 1'b1, 1'b1, 32'(MC - 1), 32'h0);
    repeat (3) tick(1'b0, 1'b0, 1'b1, 32'h6004, HW);
    check_out("timeout_frozen", 1'b0, 1'b0, 1'b1, 1'b1, 32'(MC - 1), 32'h0);

    // Halt on the last budget cycle wins over timeout
    tick(1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
    check_out("restart_from_timeout", 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'h0);
    repeat (RC) tick(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    run_incrementing(MC - 1, 32'h7000);
    tick(1'b0, 1'b0, 1'b1, 32'h7800, HW);
    check_out("halt_beats_timeout", 1'b0, 1'b0, 1'b1, 1'b0, 32'(MC), 32'h7800);

    // Reset mid-run, then mid-hold, restarting the hold count
    tick(1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
    repeat (RC) tick(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    run_incrementing(3, 32'h8000);
    tick(1'b1, 1'b1, 1'b1, 32'h8100, HW);
    check_out("mid_run_reset", 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'h0);
    repeat (3) tick(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (RC - 1) tick(1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
    check_out("mid_hold_reset_hold", 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'h0);
    tick(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    check_out("mid_hold_reset_run", 1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 32'h0);

    // Random traffic against the model
    cur_pc = 32'h0;
    for (int i = 0; i < 1500; i++) begin
      r  = (i == 0) || ($urandom_range(0, 99) < 2);
      rs = ($urandom_range(0, 7) == 0);
      pv = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) >= 8) cur_pc = 32'(4 * $urandom_range(0, 15));
      ins = ($urandom_range(0, 39) == 0) ? HW : 32'($urandom_range(0, 65535));
      tick(r, rs, pv, cur_pc, ins);
      check_out($sformatf("rand%0d", i), (m_mode == M_HOLD), (m_mode == M_RUN),
                (m_mode == M_HALT) || (m_mode == M_TO), (m_mode == M_TO),
                32'(m_cycles), m_hpc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
